// File: rtl/mem_stage_sram_pkg.sv
// Shared definitions for the MEM stage: memory-signal bit positions,
// SRAM access FSM encoding and the default data-segment base address.
package mem_stage_sram_pkg;

  localparam int MEM_R_BIT = 1;
  localparam int MEM_W_BIT = 0;

  localparam int DATA_BASE_DEFAULT = 1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mem_stage_sram_if.sv
// EXE/MEM register outputs consumed by the MEM stage, plus the pause
// returned upstream.
// Handshake: while pause is high the EXE side holds every field stable;
// the instruction is consumed at the rising edge on which pause is low.
interface mem_stage_sram_if;
  logic        WB_En_EXE;
  logic [1:0]  MEM_Signal_EXE;
  logic [4:0]  dest_EXE;
  logic [31:0] ALU_result_EXE;
  logic [31:0] reg2_EXE;
  logic        pause;

  modport master (
    output WB_En_EXE, MEM_Signal_EXE, dest_EXE, ALU_result_EXE, reg2_EXE,
    input  pause
  );

  modport slave (
    input  WB_En_EXE, MEM_Signal_EXE, dest_EXE, ALU_result_EXE, reg2_EXE,
    output pause
  );
endinterface

// File: rtl/mem_stage_sram_sram_controller.sv
// Splits each 32-bit load/store into two half-word accesses on a 16-bit
// asynchronous SRAM and holds the pipeline paused until the word is done.
module sram_controller
  import mem_stage_sram_pkg::*;
#(
  parameter int DATA_BASE = DATA_BASE_DEFAULT,
  parameter int SRAM_WAIT = 1,
  parameter int SRAM_AW   = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mem_signal,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  output logic               pause,
  output logic [31:0]        rdata,
  output state_t             state_dbg,
  output logic [SRAM_AW-1:0] sram_addr,
  inout  wire  [15:0]        sram_dq,
  output logic               sram_we_n
);

  localparam int CW = (SRAM_WAIT > 1) ? $clog2(SRAM_WAIT) : 1;

  state_t              state, state_next;
  logic [CW-1:0]       cnt, cnt_next;
  logic [31:0]         data_q, data_next;
  logic                is_rd, is_wr, req, last;
  logic [SRAM_AW-2:0]  idx;

  // 2'b11 counts as a load: the read bit wins and suppresses the write
  assign is_rd = mem_signal[MEM_R_BIT];
  assign is_wr = mem_signal[MEM_W_BIT] & ~is_rd;
  assign req   = is_rd | mem_signal[MEM_W_BIT];
  assign last  = (cnt == CW'(SRAM_WAIT - 1));
  assign idx   = (SRAM_AW-1)'((addr - 32'(DATA_BASE)) >> 2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      data_q <= '0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      data_q <= data_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    data_next  = data_q;
    case (state)
      IDLE: begin
        if (req) begin
          state_next = LO;
          cnt_next   = '0;
        end
      end
      LO: begin
        if (last) begin
          state_next = HI;
          cnt_next   = '0;
          if (is_rd) data_next[15:0] = sram_dq;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      HI: begin
        if (last) begin
          state_next = DONE;
          cnt_next   = '0;
          if (is_rd) data_next[31:16] = sram_dq;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // DONE keeps the high address up so the high half can be read straight off the bus
  always_comb begin
    sram_addr = '0;
    case (state)
      LO:      sram_addr = {idx, 1'b0};
      HI:      sram_addr = {idx, 1'b1};
      DONE:    sram_addr = {idx, 1'b1};
      default: sram_addr = '0;
    endcase
  end

  assign sram_we_n = ~(is_wr & ((state == LO) | (state == HI)));
  assign sram_dq   = ~sram_we_n ? ((state == HI) ? wdata[31:16] : wdata[15:0]) : 16'hzzzz;
  assign pause     = req & (state != DONE);
  assign rdata     = {(state == DONE) ? sram_dq : data_q[31:16], data_q[15:0]};
  assign state_dbg = state;

endmodule

// File: rtl/mem_stage_sram.sv
// MEM pipeline stage: SRAM-backed loads/stores through sram_controller,
// followed by the MEM/WB register that freezes while pause is high.
module mem_stage_sram
  import mem_stage_sram_pkg::*;
#(
  parameter int DATA_BASE = DATA_BASE_DEFAULT,
  parameter int SRAM_WAIT = 1,
  parameter int SRAM_AW   = 18
) (
  input  logic               clk,
  input  logic               rst,
  mem_stage_sram_if.slave    exe,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  inout  wire  [15:0]        SRAM_DQ,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N,
  output logic               WB_en_MEM,
  output logic               MEM_R_en_MEM,
  output logic [4:0]         dest_MEM,
  output logic [31:0]        ALU_result_MEM,
  output logic [31:0]        mem_data_MEM,
  output state_t             state_dbg
);

  logic        pause;
  logic [31:0] rdata;

  sram_controller #(
    .DATA_BASE (DATA_BASE),
    .SRAM_WAIT (SRAM_WAIT),
    .SRAM_AW   (SRAM_AW)
  ) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .mem_signal (exe.MEM_Signal_EXE),
    .addr       (exe.ALU_result_EXE),
    .wdata      (exe.reg2_EXE),
    .pause      (pause),
    .rdata      (rdata),
    .state_dbg  (state_dbg),
    .sram_addr  (SRAM_ADDR),
    .sram_dq    (SRAM_DQ),
    .sram_we_n  (SRAM_WE_N)
  );

  assign exe.pause = pause;
  assign SRAM_OE_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

  // Holding during pause keeps the WB forwarding value stable for the frozen EXE op
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      WB_en_MEM      <= 1'b0;
      MEM_R_en_MEM   <= 1'b0;
      dest_MEM       <= '0;
      ALU_result_MEM <= '0;
      mem_data_MEM   <= '0;
    end else if (!pause) begin
      WB_en_MEM      <= exe.WB_En_EXE;
      MEM_R_en_MEM   <= exe.MEM_Signal_EXE[MEM_R_BIT];
      dest_MEM       <= exe.dest_EXE;
      ALU_result_MEM <= exe.ALU_result_EXE;
      mem_data_MEM   <= rdata;
    end
  end

endmodule

// File: tb/tb_mem_stage_sram.sv
// Directed bench for mem_stage_sram: default build with a 64-entry SRAM
// model, plus a SRAM_WAIT=3 build for wait-state timing.
module tb_mem_stage_sram;
  import mem_stage_sram_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] exp_q[$];
  logic [17:0] addr_log[$];
  logic        we_log[$];

  // ---------------- default build ----------------
  mem_stage_sram_if exe1();
  logic [17:0] sram_addr1;
  wire  [15:0] sram_dq1;
  logic        we_n1, oe_n1, ce_n1, ub_n1, lb_n1;
  logic        wb_en1, mem_r1;
  logic [4:0]  dest1;
  logic [31:0] alu1, mdata1;
  state_t      st1;
  logic [15:0] mem1 [0:63];

  mem_stage_sram dut1 (
    .clk(clk), .rst(rst), .exe(exe1),
    .SRAM_ADDR(sram_addr1), .SRAM_DQ(sram_dq1), .SRAM_WE_N(we_n1),
    .SRAM_OE_N(oe_n1), .SRAM_CE_N(ce_n1), .SRAM_UB_N(ub_n1), .SRAM_LB_N(lb_n1),
    .WB_en_MEM(wb_en1), .MEM_R_en_MEM(mem_r1), .dest_MEM(dest1),
    .ALU_result_MEM(alu1), .mem_data_MEM(mdata1), .state_dbg(st1)
  );

  // ---------------- SRAM_WAIT = 3 build ----------------
  mem_stage_sram_if exe2();
  logic [17:0] sram_addr2;
  wire  [15:0] sram_dq2;
  logic        we_n2, oe_n2, ce_n2, ub_n2, lb_n2;
  logic        wb_en2, mem_r2;
  logic [4:0]  dest2;
  logic [31:0] alu2, mdata2;
  state_t      st2;
  logic [15:0] mem2 [0:63];

  mem_stage_sram #(.SRAM_WAIT(3)) dut2 (
    .clk(clk), .rst(rst), .exe(exe2),
    .SRAM_ADDR(sram_addr2), .SRAM_DQ(sram_dq2), .SRAM_WE_N(we_n2),
    .SRAM_OE_N(oe_n2), .SRAM_CE_N(ce_n2), .SRAM_UB_N(ub_n2), .SRAM_LB_N(lb_n2),
    .WB_en_MEM(wb_en2), .MEM_R_en_MEM(mem_r2), .dest_MEM(dest2),
    .ALU_result_MEM(alu2), .mem_data_MEM(mdata2), .state_dbg(st2)
  );

  // ---------------- clock / SRAM models ----------------
  always #5 clk = ~clk;

  assign sram_dq1 = we_n1 ? mem1[sram_addr1[5:0]] : 16'hzzzz;
  assign sram_dq2 = we_n2 ? mem2[sram_addr2[5:0]] : 16'hzzzz;

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) begin
        mem1[i] <= 16'h0000;
        mem2[i] <= 16'h0000;
      end
      mem1[0] <= 16'h1357;
      mem1[4] <= 16'hC0DE;
      mem1[5] <= 16'h7E57;
      mem2[0] <= 16'h5678;
      mem2[1] <= 16'h1234;
    end else begin
      if (!we_n1) mem1[sram_addr1[5:0]] <= sram_dq1;
      if (!we_n2) mem2[sram_addr2[5:0]] <= sram_dq2;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic set_exe1(input logic wb, input logic [1:0] sig, input logic [4:0] dst,
                          input logic [31:0] alu, input logic [31:0] r2);
    exe1.WB_En_EXE      = wb;
    exe1.MEM_Signal_EXE = sig;
    exe1.dest_EXE       = dst;
    exe1.ALU_result_EXE = alu;
    exe1.reg2_EXE       = r2;
  endtask

  // Presents one instruction, counts pause cycles, then returns just after
  // the edge where the MEM/WB register captured it.
  task automatic run_op(input logic wb, input logic [1:0] sig, input logic [4:0] dst,
                        input logic [31:0] alu, input logic [31:0] r2, output int pc);
    logic [31:0] snap_alu;
    logic [4:0]  snap_dst;
    bit          done;
    set_exe1(wb, sig, dst, alu, r2);
    snap_alu = alu1;
    snap_dst = dest1;
    addr_log.delete();
    we_log.delete();
    pc   = 0;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (exe1.pause) begin
        pc++;
        addr_log.push_back(sram_addr1);
        we_log.push_back(we_n1);
        check("hold_alu", alu1, snap_alu);
        check("hold_dest", {27'b0, dest1}, {27'b0, snap_dst});
      end else begin
        done = 1;
      end
    end
    if (!done) check("pause_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    set_exe1(1'b0, 2'b00, 5'd0, 32'd0, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  int pc;
  int pc2;
  bit done2;

  initial begin
    set_exe1(1'b0, 2'b00, 5'd0, 32'd0, 32'd0);
    exe2.WB_En_EXE      = 1'b0;
    exe2.MEM_Signal_EXE = 2'b00;
    exe2.dest_EXE       = 5'd0;
    exe2.ALU_result_EXE = 32'd0;
    exe2.reg2_EXE       = 32'd0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_state", {30'b0, st1}, {30'b0, IDLE});
    check("rst_we_n", {31'b0, we_n1}, 32'd1);
    check("rst_addr", {14'b0, sram_addr1}, 32'd0);
    check("rst_mem_data", mdata1, 32'd0);
    check("rst_pause", {31'b0, exe1.pause}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // store 0xDEADBEEF at 1028 -> SRAM[2]/SRAM[3]
    run_op(1'b0, 2'b01, 5'd0, 32'd1028, 32'hDEADBEEF, pc);
    check("st_pause_cycles", pc, 32'd3);
    check("st_we_idle", {31'b0, we_log[0]}, 32'd1);
    check("st_we_lo", {31'b0, we_log[1]}, 32'd0);
    check("st_we_hi", {31'b0, we_log[2]}, 32'd0);
    check("st_addr_lo", {14'b0, addr_log[1]}, 32'd2);
    check("st_addr_hi", {14'b0, addr_log[2]}, 32'd3);
    check("st_sram2", {16'b0, mem1[2]}, 32'h0000BEEF);
    check("st_sram3", {16'b0, mem1[3]}, 32'h0000DEAD);
    check("st_alu_mem", alu1, 32'd1028);
    check("st_wb_en", {31'b0, wb_en1}, 32'd0);
    check("st_mem_r", {31'b0, mem_r1}, 32'd0);

    // load it back
    exp_q.push_back(32'hDEADBEEF);
    run_op(1'b1, 2'b10, 5'd3, 32'd1028, 32'd0, pc);
    check("ld_pause_cycles", pc, 32'd3);
    check("ld_data", mdata1, exp_q.pop_front());
    check("ld_mem_r", {31'b0, mem_r1}, 32'd1);
    check("ld_dest", {27'b0, dest1}, 32'd3);
    check("ld_wb_en", {31'b0, wb_en1}, 32'd1);

    // plain ALU op: no pause, one-cycle pass-through
    run_op(1'b1, 2'b00, 5'd7, 32'h5, 32'd0, pc);
    check("alu_pause_cycles", pc, 32'd0);
    check("alu_result", alu1, 32'h5);
    check("alu_dest", {27'b0, dest1}, 32'd7);
    check("alu_wb_en", {31'b0, wb_en1}, 32'd1);
    check("alu_mem_r", {31'b0, mem_r1}, 32'd0);

    // back-to-back load then store
    exp_q.push_back(32'hDEADBEEF);
    run_op(1'b1, 2'b10, 5'd9, 32'd1028, 32'd0, pc);
    check("b2b_ld_pause", pc, 32'd3);
    check("b2b_ld_data", mdata1, exp_q.pop_front());
    check("b2b_ld_dest", {27'b0, dest1}, 32'd9);
    run_op(1'b0, 2'b01, 5'd0, 32'd1028, 32'h12345678, pc);
    check("b2b_st_pause", pc, 32'd3);
    check("b2b_st_sram2", {16'b0, mem1[2]}, 32'h00005678);
    check("b2b_st_sram3", {16'b0, mem1[3]}, 32'h00001234);

    // illegal 2'b11 at 1032 behaves as a load
    exp_q.push_back(32'h7E57C0DE);
    run_op(1'b1, 2'b11, 5'd4, 32'd1032, 32'hFFFFFFFF, pc);
    check("ill_pause_cycles", pc, 32'd3);
    for (int i = 0; i < we_log.size(); i++) check($sformatf("ill_we%0d", i), {31'b0, we_log[i]}, 32'd1);
    check("ill_sram4", {16'b0, mem1[4]}, 32'h0000C0DE);
    check("ill_data", mdata1, exp_q.pop_front());
    check("ill_mem_r", {31'b0, mem_r1}, 32'd1);

    // asynchronous reset in the middle of a store's LO phase
    set_exe1(1'b1, 2'b01, 5'd6, 32'd1040, 32'hCAFEF00D);
    @(posedge clk);
    #1;
    check("mid_state_lo", {30'b0, st1}, {30'b0, LO});
    check("mid_we_low", {31'b0, we_n1}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_state", {30'b0, st1}, {30'b0, IDLE});
    check("arst_we_n", {31'b0, we_n1}, 32'd1);
    check("arst_addr", {14'b0, sram_addr1}, 32'd0);
    check("arst_dq", {16'b0, sram_dq1}, 32'h00001357);
    check("arst_wb_en", {31'b0, wb_en1}, 32'd0);
    check("arst_mem_r", {31'b0, mem_r1}, 32'd0);
    check("arst_dest", {27'b0, dest1}, 32'd0);
    check("arst_alu", alu1, 32'd0);
    check("arst_mem_data", mdata1, 32'd0);
    check("arst_pause", {31'b0, exe1.pause}, 32'd1);
    set_exe1(1'b0, 2'b00, 5'd0, 32'd0, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // SRAM_WAIT = 3: load at 1024
    exe2.WB_En_EXE      = 1'b1;
    exe2.MEM_Signal_EXE = 2'b10;
    exe2.dest_EXE       = 5'd1;
    exe2.ALU_result_EXE = 32'd1024;
    exp_q.push_back(32'h12345678);
    addr_log.delete();
    pc2   = 0;
    done2 = 0;
    for (int i = 0; i < 40 && !done2; i++) begin
      @(negedge clk);
      if (exe2.pause) begin
        pc2++;
        addr_log.push_back(sram_addr2);
      end else begin
        done2 = 1;
      end
    end
    if (!done2) check("w3_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    exe2.MEM_Signal_EXE = 2'b00;
    check("w3_pause_cycles", pc2, 32'd7);
    for (int i = 1; i < 4 && i < addr_log.size(); i++) check($sformatf("w3_addr_lo%0d", i), {14'b0, addr_log[i]}, 32'd0);
    for (int i = 4; i < 7 && i < addr_log.size(); i++) check($sformatf("w3_addr_hi%0d", i), {14'b0, addr_log[i]}, 32'd1);
    check("w3_data", mdata2, exp_q.pop_front());
    check("w3_mem_r", {31'b0, mem_r2}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
